// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-slot register-file writeback arbiter (ALU and load requesters)
//
// Ports:
//   Clk, Rst_n             rising-edge clock, synchronous active-low reset
//   AluValid/AluAddr/AluData/AluReady   ALU writeback request handshake
//   MemValid/MemAddr/MemData/MemReady   load writeback request handshake
//   Flush                  drops both buffered requests this edge
//   Addr3/WriteData/WriteEnable         registered register-file write port
//   PendingMask            one bit per register with a write buffered or on the port

module rf_write_arbiter (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        AluValid,
    input  logic [4:0]  AluAddr,
    input  logic [31:0] AluData,
    output logic        AluReady,
    input  logic        MemValid,
    input  logic [4:0]  MemAddr,
    input  logic [31:0] MemData,
    output logic        MemReady,
    input  logic        Flush,
    output logic [4:0]  Addr3,
    output logic [31:0] WriteData,
    output logic        WriteEnable,
    output logic [31:0] PendingMask
);

    // One slot per requester; *_young marks the slot that arrived after the other.
    logic        alu_full;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_young;

    logic        mem_full;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_young;

    // Round-robin pointer: 1 = MEM wins the next different-address contest.
    logic        rr_mem;

    logic        alu_fill;
    logic        mem_fill;
    logic        pick_mem;
    logic        grant_alu;
    logic        grant_mem;
    logic        alu_stays;
    logic        mem_stays;

    // Handshake. A full slot is never ready, so a slot being granted this
    // edge cannot be refilled on the same edge.
    always_comb begin
        AluReady = !alu_full && !Flush && Rst_n;
        MemReady = !mem_full && !Flush && Rst_n;
    end

    // Register 0 requests complete the handshake but never occupy a slot.
    always_comb begin
        alu_fill = AluValid && AluReady && (AluAddr != 5'd0);
        mem_fill = MemValid && MemReady && (MemAddr != 5'd0);
    end

    // Grant selection. Same-address pairs must drain in arrival order so the
    // register ends with the youngest value; otherwise alternate fairly.
    always_comb begin
        pick_mem = 1'b0;
        if (alu_full && mem_full) begin
            if (alu_addr == mem_addr) begin
                pick_mem = !mem_young;
            end else begin
                pick_mem = rr_mem;
            end
        end else begin
            pick_mem = mem_full;
        end
        grant_alu = !Flush && alu_full && !pick_mem;
        grant_mem = !Flush && mem_full && pick_mem;
    end

    always_comb begin
        alu_stays = alu_full && !grant_alu;
        mem_stays = mem_full && !grant_mem;
    end

    // ALU slot
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            alu_full <= 1'b0;
            alu_addr <= 5'd0;
            alu_data <= 32'd0;
        end else if (Flush) begin
            alu_full <= 1'b0;
        end else if (alu_fill) begin
            alu_full <= 1'b1;
            alu_addr <= AluAddr;
            alu_data <= AluData;
        end else if (grant_alu) begin
            alu_full <= 1'b0;
        end
    end

    // MEM slot
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            mem_full <= 1'b0;
            mem_addr <= 5'd0;
            mem_data <= 32'd0;
        end else if (Flush) begin
            mem_full <= 1'b0;
        end else if (mem_fill) begin
            mem_full <= 1'b1;
            mem_addr <= MemAddr;
            mem_data <= MemData;
        end else if (grant_mem) begin
            mem_full <= 1'b0;
        end
    end

    // Age bits. A slot is young if the other slot holds an older entry after
    // this edge; a simultaneous fill makes the ALU entry the younger one.
    // Filling a slot clears the stale young bit of the other slot.
    always_ff @(posedge Clk) begin
        if (!Rst_n || Flush) begin
            alu_young <= 1'b0;
            mem_young <= 1'b0;
        end else begin
            if (alu_fill) begin
                alu_young <= mem_stays || mem_fill;
            end else if (mem_fill) begin
                alu_young <= 1'b0;
            end
            if (mem_fill) begin
                mem_young <= alu_stays;
            end else if (alu_fill) begin
                mem_young <= 1'b0;
            end
        end
    end

    // Round-robin pointer tracks the last granted requester.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rr_mem <= 1'b1;
        end else if (grant_alu) begin
            rr_mem <= 1'b1;
        end else if (grant_mem) begin
            rr_mem <= 1'b0;
        end
    end

    // Write port. Address and data hold when nothing is granted.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            WriteEnable <= 1'b0;
            Addr3       <= 5'd0;
            WriteData   <= 32'd0;
        end else if (grant_mem) begin
            WriteEnable <= 1'b1;
            Addr3       <= mem_addr;
            WriteData   <= mem_data;
        end else if (grant_alu) begin
            WriteEnable <= 1'b1;
            Addr3       <= alu_addr;
            WriteData   <= alu_data;
        end else begin
            WriteEnable <= 1'b0;
        end
    end

    // Scoreboard view for hazard logic; bit 0 is forced low as register 0 is never written.
    always_comb begin
        PendingMask = 32'd0;
        if (alu_full) begin
            PendingMask[alu_addr] = 1'b1;
        end
        if (mem_full) begin
            PendingMask[mem_addr] = 1'b1;
        end
        if (WriteEnable) begin
            PendingMask[Addr3] = 1'b1;
        end
        PendingMask[0] = 1'b0;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst_n  input  1  synchronous active-low reset, sampled on rising Clk.
REQ-004 AluValid  input  1  ALU writeback request valid.
REQ-005 AluAddr  input  5  ALU destination register.
REQ-006 AluData  input  32  ALU result.
REQ-007 AluReady  output  1  ALU slot can accept this cycle.
REQ-008 MemValid  input  1  load writeback request valid.
REQ-009 MemAddr  input  5  load destination register.
REQ-010 MemData  input  32  load data.
REQ-011 MemReady  output  1  MEM slot can accept this cycle.
REQ-012 Flush  input  1  discard all buffered, not-yet-issued requests.
REQ-013 Addr3  output  5  register-file write address (registered).
REQ-014 WriteData  output  32  register-file write data (registered).
REQ-015 WriteEnable  output  1  register-file write strobe (registered).
REQ-016 PendingMask  output  32  bit n = 1 while a write to register n is buffered or on the write port.

Function
REQ-017 SHALL hold one slot per requester (valid bit, 5-bit addr, 32-bit data, age bit); slot is the only buffering.
REQ-018 AluReady = ALU slot empty AND NOT Flush; MemReady = MEM slot empty AND NOT Flush; combinational.
REQ-019 Accept = Valid AND Ready at rising Clk; slot fills that edge.
REQ-020 Request with Addr = 0 SHALL be accepted (handshake completes) but not stored; no write ever issued to register 0.
REQ-021 Age: slot filled while the other slot is full is younger; both filled on the same edge -> MEM slot older.
REQ-022 Each cycle, if any slot full, exactly one slot SHALL be granted; granted slot empties at that edge, its addr/data load into Addr3/WriteData, WriteEnable = 1 the following cycle.
REQ-023 Only one slot full -> grant it.
REQ-024 Both full, different addresses -> round-robin: grant the requester not granted last; pointer after reset favours MEM.
REQ-025 Both full, same address -> grant the older slot first, regardless of round-robin pointer; pointer updated normally.
REQ-026 No slot full -> WriteEnable = 0 next cycle; Addr3/WriteData hold previous values.
REQ-027 Latency: accepted at edge E0 with empty other slot -> WriteEnable high in cycle after E1; register file writes at E2.
REQ-028 A slot granted at edge E SHALL be shown Ready in the cycle after E (no same-cycle refill through the grant).
REQ-029 Sustained throughput SHALL be one write per cycle; a requester alone achieves one accept per two cycles.
REQ-030 Flush high at edge: both slots cleared, no accept, no grant; WriteEnable/Addr3/WriteData register already loaded still issues.
REQ-031 PendingMask = OR of decoded addresses of full slots and of Addr3 when WriteEnable = 1; combinational from registered state; bit 0 always 0.

Reset
REQ-032 Rst_n = 0 at edge: both slots empty, WriteEnable = 0, Addr3 = 0, WriteData = 0, round-robin pointer = MEM, PendingMask = 0.
REQ-033 During reset AluReady = MemReady = 0; reset mid-operation SHALL drop all buffered requests without writing them.
REQ-034 Reset SHALL dominate Flush and all requests.

Verification
REQ-035 Single ALU write: AluValid, AluAddr=5, AluData=0x1234 one cycle -> WriteEnable=1, Addr3=5, WriteData=0x1234 exactly two edges later, PendingMask bit 5 high from edge 1 until WriteEnable drops.
REQ-036 Same-cycle, different addresses: ALU(3,0xA), MEM(4,0xB) -> writes MEM 4/0xB then ALU 3/0xA on consecutive cycles.
REQ-037 Same-address ordering: MEM(7,0x1) accepted, next cycle ALU(7,0x2) while MEM slot still full -> write 0x1 then 0x2; final reg 7 = 0x2.
REQ-038 Address 0: AluValid, AluAddr=0, AluData=0xFFFF -> AluReady=1, no WriteEnable pulse, PendingMask stays 0.
REQ-039 Flush: both slots full (1,0x11),(2,0x22), Flush one cycle before grant edge -> no writes to 1 or 2, PendingMask 0, Ready high next cycle.
REQ-040 Reset mid-stream: continuous alternating requests, Rst_n=0 one edge -> all outputs at REQ-032 values next cycle; first post-reset both-full grant goes to MEM.
